frame_load_arbiter: RTL and testbench

Shares the display back-buffer write port between two frame loaders: requester 0 is the SPI loader, requester 1 is the UART loader. A requester wins the port for a whole frame and keeps it until that frame is loaded or aborted. After a completed load, the block holds the buffer until the driver's frame_complete, then toggles the memory flip. It sits between the loaders and display_memory and owns the flip/ready handshake.

---
 rtl/frame_load_arbiter.sv | 177 +++++++++++++++++
 tb/tb_frame_load_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_load_arbiter.sv
// frame_load_arbiter
//   Shares the display back-buffer write port between two frame loaders
//   (requester 0 = SPI, requester 1 = UART). A requester owns the port for a
//   whole frame. After a completed load the buffer is held until the driver's
//   frame_complete, which toggles mem_flip and bumps frame_count.
//
// Ports:
//   clk, rst              system clock, asynchronous active-low reset
//   req[1:0]              per-requester session active
//   wen[1:0]              per-requester pixel write strobe
//   wrow0/1, wcol0/1      per-requester pixel address
//   wdata0/1              per-requester pixel data
//   loaded[1:0]           per-requester frame-done pulse
//   frame_complete        driver end-of-frame pulse
//   grant[1:0]            one-hot owner, 0 when none
//   ready[1:0]            owner may stream pixels
//   mem_wen/wrow/wcol/wdata  registered write port to display_memory
//   mem_flip              buffer select, toggles once per presented frame
//   aborted               one-cycle pulse when a load is abandoned
//   frame_count           flipped-frame counter, wraps
module frame_load_arbiter #(
  parameter int unsigned rows    = 8,
  parameter int unsigned columns = 32,
  parameter int unsigned width   = 48,
  parameter int unsigned timeout = 1000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 req,
  input  logic [1:0]                 wen,
  input  logic [$clog2(rows)-1:0]    wrow0,
  input  logic [$clog2(rows)-1:0]    wrow1,
  input  logic [$clog2(columns)-1:0] wcol0,
  input  logic [$clog2(columns)-1:0] wcol1,
  input  logic [width-1:0]           wdata0,
  input  logic [width-1:0]           wdata1,
  input  logic [1:0]                 loaded,
  input  logic                       frame_complete,
  output logic [1:0]                 grant,
  output logic [1:0]                 ready,
  output logic                       mem_wen,
  output logic [$clog2(rows)-1:0]    mem_wrow,
  output logic [$clog2(columns)-1:0] mem_wcol,
  output logic [width-1:0]           mem_wdata,
  output logic                       mem_flip,
  output logic                       aborted,
  output logic [7:0]                 frame_count
);

  localparam int unsigned RowW = $clog2(rows);
  localparam int unsigned ColW = $clog2(columns);
  localparam int unsigned CntW = $clog2(timeout + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StPending} state_e;

  state_e            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              last_q, last_d;  // 1: UART was granted last
  logic              mem_wen_q, mem_wen_d;
  logic [RowW-1:0]   mem_wrow_q, mem_wrow_d;
  logic [ColW-1:0]   mem_wcol_q, mem_wcol_d;
  logic [width-1:0]  mem_wdata_q, mem_wdata_d;
  logic              flip_q, flip_d;
  logic              aborted_q, aborted_d;
  logic [7:0]        count_q, count_d;
  logic [CntW-1:0]   idle_q, idle_d;

  logic owner_wen, owner_req, owner_loaded, win;

  // Only the owner's strobes matter; grant_q is zero outside LOAD/PENDING.
  assign owner_wen    = |(wen & grant_q);
  assign owner_req    = |(req & grant_q);
  assign owner_loaded = |(loaded & grant_q);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    mem_wen_d   = 1'b0;
    mem_wrow_d  = mem_wrow_q;
    mem_wcol_d  = mem_wcol_q;
    mem_wdata_d = mem_wdata_q;
    flip_d      = flip_q;
    aborted_d   = 1'b0;
    count_d     = count_q;
    idle_d      = idle_q;
    win         = 1'b0;

    case (state_q)
      StIdle: begin
        if (|req) begin
          // On a tie the requester not granted last wins.
          win     = (req == 2'b11) ? ~last_q : req[1];
          grant_d = win ? 2'b10 : 2'b01;
          last_d  = win;
          idle_d  = '0;
          state_d = StLoad;
        end
      end

      StLoad: begin
        // A write coinciding with loaded is still forwarded.
        if (owner_wen) begin
          mem_wen_d   = 1'b1;
          mem_wrow_d  = grant_q[1] ? wrow1 : wrow0;
          mem_wcol_d  = grant_q[1] ? wcol1 : wcol0;
          mem_wdata_d = grant_q[1] ? wdata1 : wdata0;
          idle_d      = '0;
        end else begin
          idle_d = idle_q + CntW'(1);
        end

        if (owner_loaded) begin
          state_d = StPending;
        end else if (!owner_req || (!owner_wen && idle_q == CntW'(timeout - 1))) begin
          aborted_d = 1'b1;
          grant_d   = 2'b00;
          state_d   = StIdle;
        end
      end

      StPending: begin
        // req drops are ignored here; the completed frame is always flipped.
        if (frame_complete) begin
          flip_d  = ~flip_q;
          count_d = count_q + 8'd1;
          grant_d = 2'b00;
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      grant_q     <= 2'b00;
      last_q      <= 1'b1;
      mem_wen_q   <= 1'b0;
      mem_wrow_q  <= '0;
      mem_wcol_q  <= '0;
      mem_wdata_q <= '0;
      flip_q      <= 1'b0;
      aborted_q   <= 1'b0;
      count_q     <= 8'd0;
      idle_q      <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      mem_wen_q   <= mem_wen_d;
      mem_wrow_q  <= mem_wrow_d;
      mem_wcol_q  <= mem_wcol_d;
      mem_wdata_q <= mem_wdata_d;
      flip_q      <= flip_d;
      aborted_q   <= aborted_d;
      count_q     <= count_d;
      idle_q      <= idle_d;
    end
  end

  assign grant       = grant_q;
  assign ready       = (state_q == StLoad) ? grant_q : 2'b00;
  assign mem_wen     = mem_wen_q;
  assign mem_wrow    = mem_wrow_q;
  assign mem_wcol    = mem_wcol_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_flip    = flip_q;
  assign aborted     = aborted_q;
  assign frame_count = count_q;

endmodule

// File: tb/tb_frame_load_arbiter.sv
// Directed bench for frame_load_arbiter (timeout shortened to 100).
module tb_frame_load_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, wen, loaded;
  logic [2:0]  wrow0, wrow1;
  logic [4:0]  wcol0, wcol1;
  logic [47:0] wdata0, wdata1;
  logic        frame_complete;
  logic [1:0]  grant, ready;
  logic        mem_wen;
  logic [2:0]  mem_wrow;
  logic [4:0]  mem_wcol;
  logic [47:0] mem_wdata;
  logic        mem_flip, aborted;
  logic [7:0]  frame_count;

  int n_cmp = 0;
  int n_err = 0;

  frame_load_arbiter #(
    .rows(8), .columns(32), .width(48), .timeout(100)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .wen(wen),
    .wrow0(wrow0), .wrow1(wrow1), .wcol0(wcol0), .wcol1(wcol1),
    .wdata0(wdata0), .wdata1(wdata1), .loaded(loaded),
    .frame_complete(frame_complete), .grant(grant), .ready(ready),
    .mem_wen(mem_wen), .mem_wrow(mem_wrow), .mem_wcol(mem_wcol),
    .mem_wdata(mem_wdata), .mem_flip(mem_flip), .aborted(aborted),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    wen = 2'b00; loaded = 2'b00; frame_complete = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; req = 2'b00; quiet();
    tick();
    rst = 1'b1;
  endtask

  function automatic logic [47:0] pix(input int i, input int seed);
    return {16'(seed), 16'(i * 7 + 1), 16'(~i)};
  endfunction

  // Drive one pixel on a port; the other port's strobe is left as given.
  task automatic put(input int port, input int r, input int c, input logic [47:0] d);
    if (port == 0) begin
      wen[0] = 1'b1; wrow0 = 3'(r); wcol0 = 5'(c); wdata0 = d;
    end else begin
      wen[1] = 1'b1; wrow1 = 3'(r); wcol1 = 5'(c); wdata1 = d;
    end
  endtask

  initial begin
    logic [2:0]  r;
    logic [4:0]  c;
    logic [47:0] d;
    rst = 1'b0; req = 2'b00; quiet();
    wrow0 = '0; wrow1 = '0; wcol0 = '0; wcol1 = '0; wdata0 = '0; wdata1 = '0;
    #12;
    check("rst_outs", {grant, ready, mem_wen, mem_wrow, mem_wcol, mem_wdata, mem_flip,
                       aborted, frame_count}, 64'd0);
    tick();
    rst = 1'b1;

    // 1: full SPI frame, 256 pixels.
    req = 2'b01;
    tick();
    check("s1_grant", grant, 2'b01);
    check("s1_ready", ready, 2'b01);
    for (int i = 0; i < 256; i++) begin
      r = 3'(i / 32); c = 5'(i % 32); d = pix(i, 16'h5a5a);
      wen = 2'b00; put(0, r, c, d);
      tick();
      check("s1_px", {mem_wen, mem_wrow, mem_wcol, mem_wdata}, {1'b1, r, c, d});
    end
    wen = 2'b00; loaded = 2'b01;
    tick();
    loaded = 2'b00; req = 2'b00;  // req drop in PENDING must not cancel the flip
    check("s1_pend_wen", mem_wen, 1'b0);
    check("s1_pend_rdy", ready, 2'b00);
    repeat (3) tick();
    check("s1_pend_grant", grant, 2'b01);
    check("s1_pend_flip", mem_flip, 1'b0);
    frame_complete = 1'b1;
    tick();
    frame_complete = 1'b0;
    check("s1_flip", mem_flip, 1'b1);
    check("s1_count", frame_count, 8'd1);
    check("s1_grant0", grant, 2'b00);

    // 2: two ties in a row; round-robin starting with SPI.
    do_reset();
    req = 2'b11;
    tick();
    check("s2_tie1", grant, 2'b01);
    put(1, 3, 7, 48'hdead_beef_0001);
    tick();
    check("s2_uart_drop", mem_wen, 1'b0);
    wen = 2'b00;
    put(1, 4, 8, 48'hdead_beef_0002);
    put(0, 2, 9, 48'h1234_5678_9abc);
    tick();
    check("s2_spi_only", {mem_wen, mem_wrow, mem_wcol, mem_wdata},
          {1'b1, 3'd2, 5'd9, 48'h1234_5678_9abc});
    wen = 2'b00; loaded = 2'b01;
    tick();
    loaded = 2'b00; frame_complete = 1'b1;
    tick();
    frame_complete = 1'b0;
    check("s2_flip1", {mem_flip, frame_count}, {1'b1, 8'd1});
    tick();
    check("s2_tie2", grant, 2'b10);
    loaded = 2'b01;  // non-owner loaded ignored
    tick();
    loaded = 2'b00;
    check("s2_nonown_ld", ready, 2'b10);
    put(1, 7, 31, 48'hfeed_0000_cafe);
    tick();
    wen = 2'b00;
    check("s2_uart_px", {mem_wen, mem_wrow, mem_wcol, mem_wdata},
          {1'b1, 3'd7, 5'd31, 48'hfeed_0000_cafe});
    loaded = 2'b10; req = 2'b00;
    tick();
    loaded = 2'b00; frame_complete = 1'b1;
    tick();
    frame_complete = 1'b0;
    check("s2_flip2", {mem_flip, frame_count}, {1'b0, 8'd2});

    // 3: loaded coincident with frame_complete waits for the next one.
    req = 2'b01;
    tick();
    check("s3_grant", grant, 2'b01);
    put(0, 1, 1, 48'h0000_0000_0011);
    tick();
    wen = 2'b00; loaded = 2'b01; frame_complete = 1'b1;
    tick();
    quiet(); req = 2'b00;
    check("s3_noflip", {mem_flip, frame_count, ready, grant}, {1'b0, 8'd2, 2'b00, 2'b01});
    repeat (2) tick();
    check("s3_still", mem_flip, 1'b0);
    frame_complete = 1'b1;
    tick();
    frame_complete = 1'b0;
    check("s3_flip", {mem_flip, frame_count, grant}, {1'b1, 8'd3, 2'b00});

    // 4: owner req drops after 10 writes.
    req = 2'b01;
    tick();
    for (int i = 0; i < 10; i++) begin
      wen = 2'b00; put(0, 0, i, pix(i, 16'h0004));
      tick();
    end
    wen = 2'b00; req = 2'b00;
    tick();
    check("s4_abort", {aborted, grant, ready}, {1'b1, 2'b00, 2'b00});
    check("s4_keep", {mem_flip, frame_count}, {1'b1, 8'd3});
    tick();
    check("s4_pulse", aborted, 1'b0);

    // 5: idle timeout of 100 cycles.
    req = 2'b01;
    tick();
    repeat (99) tick();
    check("s5_99", {aborted, grant}, {1'b0, 2'b01});
    tick();
    check("s5_100", {aborted, grant}, {1'b1, 2'b00});
    tick();  // req still high: new load granted
    check("s5_regrant", grant, 2'b01);
    repeat (98) tick();
    put(0, 5, 5, 48'h0000_0000_0099);
    tick();
    wen = 2'b00;
    repeat (99) tick();
    check("s5_reset_cnt", {aborted, grant}, {1'b0, 2'b01});
    req = 2'b00;
    tick();
    // req dropped this same cycle, so an abort is expected either way
    check("s5_abort2", {aborted, grant}, {1'b1, 2'b00});
    tick();

    // 6: asynchronous reset mid-load.
    req = 2'b01;
    tick();
    for (int i = 0; i < 5; i++) begin
      wen = 2'b00; put(0, 6, i, pix(i, 16'h0006));
      tick();
    end
    #2;
    rst = 1'b0;
    #1;
    check("s6_async", {grant, ready, mem_wen, mem_wrow, mem_wcol, mem_wdata, mem_flip,
                       aborted, frame_count}, 64'd0);
    wen = 2'b00; req = 2'b10;
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    check("s6_uart", {grant, ready}, {2'b10, 2'b10});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
